// File: rtl/mlp_load_sequencer.sv
// Host-side load sequencer for the MLP accelerator: turns one host word stream into
// input/weight load controls, then forwards the result burst and flags done/error.
module mlp_load_sequencer #(
    parameter int NUM_LAYERS    = 8,
    parameter int ROWS          = 16,
    parameter int WORDS_PER_ROW = 8,
    parameter int WGROUPS       = 8,
    parameter int RES_WORDS     = 128,
    parameter int TIMEOUT       = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic        s_valid_i,
    input  logic [31:0] s_data_i,
    output logic        s_ready_o,
    output logic        load_en_o,
    output logic [31:0] load_payload_o,
    output logic        load_type_o,
    output logic [3:0]  input_load_number_o,
    output logic [2:0]  layer_number_o,
    output logic [2:0]  weight_number_o,
    input  logic        res_valid_i,
    input  logic [31:0] res_data_i,
    output logic        m_valid_o,
    output logic [31:0] m_data_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    localparam int WCW = $clog2(WORDS_PER_ROW);
    localparam int RCW = $clog2(ROWS);
    localparam int GCW = $clog2(WGROUPS);
    localparam int LCW = $clog2(NUM_LAYERS);
    localparam int TCW = $clog2(TIMEOUT);
    localparam int QCW = $clog2(RES_WORDS);

    localparam logic [WCW-1:0] WORD_LAST  = WCW'(WORDS_PER_ROW - 1);
    localparam logic [RCW-1:0] ROW_LAST   = RCW'(ROWS - 1);
    localparam logic [GCW-1:0] GROUP_LAST = GCW'(WGROUPS - 1);
    localparam logic [LCW-1:0] LAYER_LAST = LCW'(NUM_LAYERS - 1);
    localparam logic [TCW-1:0] WAIT_LAST  = TCW'(TIMEOUT - 1);
    localparam logic [QCW-1:0] RES_LAST   = QCW'(RES_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_IN,
        LOAD_W,
        WAIT_RES,
        DRAIN
    } state_t;

    state_t state_q, state_d;

    logic [WCW-1:0] word_cnt;
    logic [RCW-1:0] row_cnt;
    logic [GCW-1:0] wgrp_cnt;
    logic [LCW-1:0] layer_cnt;
    logic [TCW-1:0] wait_cnt;
    logic [QCW-1:0] res_cnt;

    logic xfer, in_last, w_last, res_last, res_take, set_err;

    assign s_ready_o = (state_q == LOAD_IN) || (state_q == LOAD_W);
    assign busy_o    = (state_q != IDLE);
    assign xfer      = s_valid_i && s_ready_o;
    assign in_last   = (word_cnt == WORD_LAST) && (row_cnt == ROW_LAST);
    assign w_last    = (row_cnt == ROW_LAST) && (wgrp_cnt == GROUP_LAST) && (layer_cnt == LAYER_LAST);
    assign res_last  = (res_cnt == RES_LAST);
    assign res_take  = ((state_q == WAIT_RES) || (state_q == DRAIN)) && res_valid_i && !abort_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // The first result word arrives in WAIT_RES and is forwarded like any other,
    // so a full burst is RES_WORDS consecutive res_valid_i cycles.
    always_comb begin
        state_d = state_q;
        set_err = 1'b0;
        case (state_q)
            IDLE:     if (start_i) state_d = LOAD_IN;
            LOAD_IN:  if (xfer && in_last) state_d = LOAD_W;
            LOAD_W:   if (xfer && w_last) state_d = WAIT_RES;
            WAIT_RES: begin
                if (res_valid_i) begin
                    state_d = res_last ? IDLE : DRAIN;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_d = IDLE;
                    set_err = 1'b1;
                end
            end
            DRAIN: begin
                if (res_valid_i) begin
                    state_d = res_last ? IDLE : DRAIN;
                end else begin
                    state_d = IDLE;
                    set_err = 1'b1;
                end
            end
            default:  state_d = IDLE;
        endcase
        if (abort_i) begin
            state_d = IDLE;
            set_err = 1'b0;
        end
    end

    // Counters clear on every state change; the word taken on WAIT_RES->DRAIN still counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt  <= '0;
            row_cnt   <= '0;
            wgrp_cnt  <= '0;
            layer_cnt <= '0;
            wait_cnt  <= '0;
            res_cnt   <= '0;
        end else if (state_d != state_q) begin
            word_cnt  <= '0;
            row_cnt   <= '0;
            wgrp_cnt  <= '0;
            layer_cnt <= '0;
            wait_cnt  <= '0;
            res_cnt   <= (res_take && state_d == DRAIN) ? res_cnt + 1'b1 : '0;
        end else begin
            case (state_q)
                LOAD_IN: begin
                    if (xfer) begin
                        if (word_cnt == WORD_LAST) begin
                            word_cnt <= '0;
                            row_cnt  <= row_cnt + 1'b1;
                        end else begin
                            word_cnt <= word_cnt + 1'b1;
                        end
                    end
                end
                LOAD_W: begin
                    if (xfer) begin
                        if (row_cnt == ROW_LAST) begin
                            row_cnt <= '0;
                            if (wgrp_cnt == GROUP_LAST) begin
                                wgrp_cnt  <= '0;
                                layer_cnt <= layer_cnt + 1'b1;
                            end else begin
                                wgrp_cnt <= wgrp_cnt + 1'b1;
                            end
                        end else begin
                            row_cnt <= row_cnt + 1'b1;
                        end
                    end
                end
                WAIT_RES: wait_cnt <= wait_cnt + 1'b1;
                DRAIN:    if (res_take) res_cnt <= res_cnt + 1'b1;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_en_o           <= 1'b0;
            load_payload_o      <= '0;
            load_type_o         <= 1'b0;
            input_load_number_o <= '0;
            layer_number_o      <= '0;
            weight_number_o     <= '0;
        end else begin
            load_en_o <= xfer;
            if (xfer) begin
                load_payload_o      <= s_data_i;
                load_type_o         <= (state_q == LOAD_IN);
                input_load_number_o <= row_cnt;
                layer_number_o      <= (state_q == LOAD_W) ? layer_cnt : '0;
                weight_number_o     <= (state_q == LOAD_W) ? wgrp_cnt : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_o <= 1'b0;
            m_data_o  <= '0;
            done_o    <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            m_valid_o <= res_take;
            done_o    <= res_take && res_last;
            if (res_take) m_data_o <= res_data_i;
            if (set_err) begin
                err_o <= 1'b1;
            end else if (state_q == IDLE && start_i && !abort_i) begin
                err_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mlp_load_sequencer.sv
// Directed-sequence bench for mlp_load_sequencer with randomized payloads and host gaps;
// expected load coordinates come from the word index by plain arithmetic.
module tb_mlp_load_sequencer;

    localparam int NUM_LAYERS    = 8;
    localparam int ROWS          = 16;
    localparam int WORDS_PER_ROW = 8;
    localparam int WGROUPS       = 8;
    localparam int RES_WORDS     = 128;
    localparam int IN_WORDS      = ROWS * WORDS_PER_ROW;
    localparam int W_WORDS       = NUM_LAYERS * WGROUPS * ROWS;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic        s_valid_i = 1'b0;
    logic [31:0] s_data_i = '0;
    logic        res_valid_i = 1'b0;
    logic [31:0] res_data_i = '0;
    logic        s_ready_o, load_en_o, load_type_o, m_valid_o, busy_o, done_o, err_o;
    logic [31:0] load_payload_o, m_data_o;
    logic [3:0]  input_load_number_o;
    logic [2:0]  layer_number_o, weight_number_o;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_payload = '0;

    mlp_load_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
        .s_valid_i(s_valid_i), .s_data_i(s_data_i), .s_ready_o(s_ready_o),
        .load_en_o(load_en_o), .load_payload_o(load_payload_o), .load_type_o(load_type_o),
        .input_load_number_o(input_load_number_o), .layer_number_o(layer_number_o),
        .weight_number_o(weight_number_o), .res_valid_i(res_valid_i), .res_data_i(res_data_i),
        .m_valid_o(m_valid_o), .m_data_o(m_data_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Word k of the input phase sits in row k/8; weight word k walks row, then group, then layer.
    task automatic send_word(input bit is_input, input int k, input int gaps, input bit with_abort);
        logic [31:0] d;
        int row, grp, layer;
        for (int g = 0; g < gaps; g++) begin
            s_valid_i = 1'b0;
            tick();
            check_output("gap_load_en", {31'b0, load_en_o}, 32'd0);
            check_output("gap_payload_hold", load_payload_o, last_payload);
        end
        if (is_input) begin
            row = k / WORDS_PER_ROW; grp = 0; layer = 0;
        end else begin
            row = k % ROWS; grp = (k / ROWS) % WGROUPS; layer = k / (ROWS * WGROUPS);
        end
        d = $urandom;
        s_valid_i = 1'b1;
        s_data_i  = d;
        abort_i   = with_abort;
        check_output("s_ready", {31'b0, s_ready_o}, 32'd1);
        tick();
        s_valid_i = 1'b0;
        abort_i   = 1'b0;
        check_output("load_en", {31'b0, load_en_o}, 32'd1);
        check_output("load_payload", load_payload_o, d);
        check_output("load_type", {31'b0, load_type_o}, {31'b0, is_input});
        check_output("input_row", {28'b0, input_load_number_o}, row);
        check_output("weight_group", {29'b0, weight_number_o}, grp);
        check_output("layer", {29'b0, layer_number_o}, layer);
        last_payload = d;
    endtask

    task automatic start_inference();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check_output("start_busy", {31'b0, busy_o}, 32'd1);
        check_output("start_err_clear", {31'b0, err_o}, 32'd0);
    endtask

    task automatic run_loads(input int gap_max, input int in_gaps);
        for (int k = 0; k < IN_WORDS; k++) send_word(1'b1, k, (in_gaps >= 0) ? in_gaps : $urandom_range(gap_max), 1'b0);
        for (int k = 0; k < W_WORDS; k++) send_word(1'b0, k, $urandom_range(gap_max), 1'b0);
    endtask

    task automatic deliver_results(input int n, input int pre_delay, input bit exp_err);
        logic [31:0] d;
        res_valid_i = 1'b0;
        for (int i = 0; i < pre_delay; i++) begin
            tick();
            check_output("wait_busy", {31'b0, busy_o}, 32'd1);
            check_output("wait_m_valid", {31'b0, m_valid_o}, 32'd0);
        end
        for (int i = 0; i < n; i++) begin
            d = $urandom;
            res_valid_i = 1'b1;
            res_data_i  = d;
            tick();
            check_output("m_valid", {31'b0, m_valid_o}, 32'd1);
            check_output("m_data", m_data_o, d);
            check_output("done", {31'b0, done_o}, (i == RES_WORDS - 1) ? 32'd1 : 32'd0);
        end
        res_valid_i = 1'b0;
        tick();
        check_output("end_busy", {31'b0, busy_o}, 32'd0);
        check_output("end_m_valid", {31'b0, m_valid_o}, 32'd0);
        check_output("end_done", {31'b0, done_o}, 32'd0);
        check_output("end_err", {31'b0, err_o}, {31'b0, exp_err});
    endtask

    initial begin
        // Reset with the host already presenting a word
        s_valid_i = 1'b1;
        #12;
        check_output("rst_s_ready", {31'b0, s_ready_o}, 32'd0);
        check_output("rst_busy", {31'b0, busy_o}, 32'd0);
        check_output("rst_load_en", {31'b0, load_en_o}, 32'd0);
        check_output("rst_payload", load_payload_o, 32'd0);
        check_output("rst_m_valid", {31'b0, m_valid_o}, 32'd0);
        check_output("rst_err", {31'b0, err_o}, 32'd0);
        rst_n = 1'b1;
        tick();
        tick();
        check_output("idle_s_ready", {31'b0, s_ready_o}, 32'd0);
        check_output("idle_load_en", {31'b0, load_en_o}, 32'd0);
        s_valid_i = 1'b0;

        // start together with abort in IDLE stays idle
        start_i = 1'b1;
        abort_i = 1'b1;
        tick();
        start_i = 1'b0;
        abort_i = 1'b0;
        check_output("start_abort_idle", {31'b0, busy_o}, 32'd0);

        $display("[TB] full inference with random host gaps");
        start_inference();
        for (int k = 0; k < IN_WORDS; k++) send_word(1'b1, k, $urandom_range(2), 1'b0);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check_output("start_while_busy", {31'b0, busy_o}, 32'd1);
        check_output("start_while_busy_load_en", {31'b0, load_en_o}, 32'd0);
        for (int k = 0; k < W_WORDS; k++) send_word(1'b0, k, $urandom_range(2), 1'b0);
        deliver_results(RES_WORDS, $urandom_range(20), 1'b0);

        $display("[TB] full inference without gaps");
        start_inference();
        run_loads(0, 0);
        deliver_results(RES_WORDS, 0, 1'b0);

        $display("[TB] result timeout");
        start_inference();
        run_loads(0, 0);
        for (int i = 0; i < 1000; i++) tick();
        check_output("pre_timeout_busy", {31'b0, busy_o}, 32'd1);
        check_output("pre_timeout_err", {31'b0, err_o}, 32'd0);
        for (int i = 0; i < 30; i++) tick();
        check_output("timeout_err", {31'b0, err_o}, 32'd1);
        check_output("timeout_busy", {31'b0, busy_o}, 32'd0);

        $display("[TB] alternating host valid, then short result burst");
        start_inference();
        run_loads(0, 1);
        deliver_results(50, 5, 1'b1);

        $display("[TB] abort during weight load");
        start_inference();
        for (int k = 0; k < IN_WORDS; k++) send_word(1'b1, k, 0, 1'b0);
        for (int k = 0; k < 300; k++) send_word(1'b0, k, 0, 1'b0);
        send_word(1'b0, 300, 0, 1'b1);
        check_output("abort_s_ready", {31'b0, s_ready_o}, 32'd0);
        check_output("abort_busy", {31'b0, busy_o}, 32'd0);
        check_output("abort_err", {31'b0, err_o}, 32'd0);
        start_inference();
        send_word(1'b1, 0, 0, 1'b0);
        send_word(1'b1, 1, 1, 1'b0);

        // Asynchronous reset between clock edges
        #2;
        rst_n = 1'b0;
        #1;
        check_output("async_rst_busy", {31'b0, busy_o}, 32'd0);
        check_output("async_rst_load_type", {31'b0, load_type_o}, 32'd0);
        check_output("async_rst_payload", load_payload_o, 32'd0);
        check_output("async_rst_s_ready", {31'b0, s_ready_o}, 32'd0);
        rst_n = 1'b1;
        tick();
        check_output("post_rst_busy", {31'b0, busy_o}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
